// File: rtl/writeback_unit.sv
// Write-back stage: selects one register file write per cycle from load
// returns, queued ALU results, or a direct ALU bypass. Loads are
// zero/sign-extended to 64 bits; ALU results that lose to a load wait in a
// small circular FIFO. Writes to X31 are never issued.
module writeback_unit #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_aluValid,
   input  logic [4:0]  i_aluDest,
   input  logic [63:0] i_aluResult,
   output logic        o_aluReady,
   input  logic        i_loadValid,
   input  logic [4:0]  i_loadDest,
   input  logic [63:0] i_loadData,
   input  logic [1:0]  i_loadSize,
   input  logic        i_loadSigned,
   output logic [4:0]  o_writeAddress,
   output logic [63:0] o_writeData,
   output logic        o_regwrite,
   output logic [31:0] o_pendingMask
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // FIFO storage and bookkeeping
   logic          r_valid [DEPTH];
   logic [4:0]    r_dest  [DEPTH];
   logic [63:0]   r_data  [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   // Registered write port
   logic          r_regwrite;
   logic [4:0]    r_wr_addr;
   logic [63:0]   r_wr_data;

   logic [63:0]   w_load_ext;
   logic          w_alu_accept;
   logic          w_alu_live;
   logic          w_load_live;
   logic          w_load_supp;
   logic          w_load_wr;
   logic          w_fifo_nonempty;
   logic          w_head_valid;
   logic          w_pop;
   logic          w_bypass;
   logic          w_push;

   // Acceptance depends only on the registered occupancy
   assign o_aluReady      = (r_count < DEPTH_C);
   assign w_alu_accept    = i_aluValid && o_aluReady;
   assign w_alu_live      = w_alu_accept && (i_aluDest != 5'd31);
   assign w_load_live     = i_loadValid && (i_loadDest != 5'd31);
   assign w_fifo_nonempty = (r_count != '0);
   assign w_head_valid    = r_valid[r_rd_ptr];

   // A load is older than every ALU result, so a younger write to the same
   // register (queued or arriving this cycle) makes the load value dead.
   assign w_load_supp = o_pendingMask[i_loadDest] ||
                        (w_alu_live && (i_aluDest == i_loadDest));
   assign w_load_wr   = w_load_live && !w_load_supp;
   assign w_pop       = !w_load_wr && w_fifo_nonempty;
   assign w_bypass    = !w_load_wr && !w_fifo_nonempty && w_alu_live;
   assign w_push      = w_alu_live && (w_fifo_nonempty || w_load_wr);

   // Extract the load field and extend it to 64 bits
   always_comb begin
      w_load_ext = i_loadData;
      case (i_loadSize)
         2'b00:   w_load_ext = {{56{i_loadSigned & i_loadData[7]}},  i_loadData[7:0]};
         2'b01:   w_load_ext = {{48{i_loadSigned & i_loadData[15]}}, i_loadData[15:0]};
         2'b10:   w_load_ext = {{32{i_loadSigned & i_loadData[31]}}, i_loadData[31:0]};
         default: w_load_ext = i_loadData;
      endcase
   end

   // One bit per register that still has a queued write outstanding
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_pending
         always_comb begin
            o_pendingMask[gi] = 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
               if (r_valid[e] && (r_dest[e] == 5'(gi)))
                  o_pendingMask[gi] = 1'b1;
            end
         end
      end
   endgenerate

   // FIFO control: valid bits, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < DEPTH; e++) r_valid[e] <= 1'b0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_pop) begin
            r_valid[r_rd_ptr] <= 1'b0;
            r_rd_ptr          <= r_rd_ptr + AW'(1);
         end
         if (w_push) begin
            r_valid[r_wr_ptr] <= 1'b1;
            r_wr_ptr          <= r_wr_ptr + AW'(1);
         end
         if (w_push && !w_pop)
            r_count <= r_count + CW'(1);
         else if (w_pop && !w_push)
            r_count <= r_count - CW'(1);
      end
   end

   // FIFO payload storage; contents are qualified by r_valid
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_dest[r_wr_ptr] <= i_aluDest;
         r_data[r_wr_ptr] <= i_aluResult;
      end
   end

   // Write-port selection: load, then FIFO head, then ALU bypass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_regwrite <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
      end else begin
         r_regwrite <= w_load_wr || (w_pop && w_head_valid) || w_bypass;
         if (w_load_wr) begin
            r_wr_addr <= i_loadDest;
            r_wr_data <= w_load_ext;
         end else if (w_pop) begin
            r_wr_addr <= r_dest[r_rd_ptr];
            r_wr_data <= r_data[r_rd_ptr];
         end else if (w_bypass) begin
            r_wr_addr <= i_aluDest;
            r_wr_data <= i_aluResult;
         end
      end
   end

   assign o_regwrite     = r_regwrite;
   assign o_writeAddress = r_wr_addr;
   assign o_writeData    = r_wr_data;

endmodule
